// File: rtl/div_if.sv
// div_if: divider request/result bundle between the EX stage and div_seq.
interface div_if;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  modport master (output start_i, annul_i, signed_i, opdata1_i, opdata2_i, input result_o, ready_o, stallreq_o);
  modport slave  (input start_i, annul_i, signed_i, opdata1_i, opdata2_i, output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_seq.sv
// div_seq: 32-step restoring divider, result {rem, quo}; DIV_SIGNED_EN adds signed DIV.
module div_seq (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] res_q, res_d;
  logic        rdy_q, rdy_d;
  logic [64:0] sh;
  logic [32:0] diff;
  logic [31:0] a_in, b_in, quo, rem;
`ifdef DIV_SIGNED_EN
  logic nq_q, nr_q;
  assign a_in = (bus.signed_i & bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign b_in = (bus.signed_i & bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  assign quo  = nq_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem  = nr_q ? -acc_q[63:32] : acc_q[63:32];
  // Sign corrections are captured together with the operand magnitudes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else if (state_q == FREE && bus.start_i) begin
      nq_q <= bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
      nr_q <= bus.signed_i & bus.opdata1_i[31];
    end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_i;
  assign a_in = bus.opdata1_i;
  assign b_in = bus.opdata2_i;
  assign quo  = acc_q[31:0];
  assign rem  = acc_q[63:32];
`endif
  // Partial remainder stays below the divisor, so bit 32 of diff is a clean borrow
  assign sh   = {acc_q[63:0], 1'b0};
  assign diff = sh[64:32] - {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    if (bus.annul_i) begin
      state_d = FREE;
      res_d   = '0;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        FREE:
          if (bus.start_i) begin
            state_d = (bus.opdata2_i == '0) ? BYZERO : ON;
            acc_d   = {33'b0, a_in};
            dvs_d   = b_in;
            cnt_d   = '0;
          end
        BYZERO: begin
          state_d = END;
          res_d   = '0;
          rdy_d   = 1'b1;
        end
        ON:
          if (cnt_q == 6'd32) begin
            state_d = END;
            res_d   = {rem, quo};
            rdy_d   = 1'b1;
          end else begin
            acc_d = diff[32] ? sh : {diff, sh[31:1], 1'b1};
            cnt_d = cnt_q + 6'd1;
          end
        default:
          if (!bus.start_i) begin
            state_d = FREE;
            res_d   = '0;
            rdy_d   = 1'b0;
          end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FREE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  assign bus.result_o   = res_q;
  assign bus.ready_o    = rdy_q;
  assign bus.stallreq_o = bus.start_i & ~rdy_q & ~bus.annul_i;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq latency, results, annul and reset.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  div_if bus ();
  div_seq dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
`ifdef DIV_SIGNED_EN
  localparam logic [63:0] EXP_M7_2   = 64'hFFFFFFFF_FFFFFFFD;
  localparam logic [63:0] EXP_MIN_M1 = 64'h00000000_80000000;
  localparam logic [63:0] EXP_M7_M2  = 64'hFFFFFFFF_00000003;
  localparam logic [63:0] EXP_7_M2   = 64'h00000001_FFFFFFFD;
`else
  localparam logic [63:0] EXP_M7_2   = 64'h00000001_7FFFFFFC;
  localparam logic [63:0] EXP_MIN_M1 = 64'h80000000_00000000;
  localparam logic [63:0] EXP_M7_M2  = 64'hFFFFFFF9_00000000;
  localparam logic [63:0] EXP_7_M2   = 64'h00000007_00000000;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready(output int lat, output logic [63:0] r);
    lat = -1;
    r = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        lat = i;
        r = bus.result_o;
        break;
      end
    end
  endtask
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [63:0] r);
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.signed_i  = s;
    bus.start_i   = 1'b1;
    wait_ready(lat, r);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask
  int lat;
  int bad;
  logic [63:0] r;
  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    @(negedge clk);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    #1 chk("stall_cycle0", 64'(bus.stallreq_o), 64'd1);
    bad = 0;
    for (int i = 0; i <= 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        bus.opdata1_i = 32'hDEADBEEF;
        bus.opdata2_i = 32'h0;
      end
      if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b1) bad++;
    end
    chk("busy_edges_0_32", 64'(bad), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("u100_7_ready_edge33", 64'(bus.ready_o), 64'd1);
    chk("u100_7_result", bus.result_o, 64'h00000002_0000000E);
    chk("u100_7_stall_low", 64'(bus.stallreq_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("end_hold_ready", 64'(bus.ready_o), 64'd1);
    chk("end_hold_result", bus.result_o, 64'h00000002_0000000E);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("free_ready", 64'(bus.ready_o), 64'd0);
    chk("free_result", bus.result_o, 64'd0);
    do_div(32'd5, 32'd0, 1'b0, lat, r);
    chk("byzero_latency", 64'(lat), 64'd1);
    chk("byzero_result", r, 64'd0);
    chk("byzero_free_ready", 64'(bus.ready_o), 64'd0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, lat, r);
    chk("s_m7_2_latency", 64'(lat), 64'd33);
    chk("s_m7_2", r, EXP_M7_2);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, r);
    chk("s_min_m1", r, EXP_MIN_M1);
    do_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, lat, r);
    chk("s_m7_m2", r, EXP_M7_M2);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, lat, r);
    chk("s_7_m2", r, EXP_7_M2);
    do_div(32'hFFFFFFF9, 32'd2, 1'b0, lat, r);
    chk("u_m7_2", r, 64'h00000001_7FFFFFFC);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, lat, r);
    chk("u_max_1", r, 64'h00000000_FFFFFFFF);
    do_div(32'd5, 32'd10, 1'b0, lat, r);
    chk("u_5_10", r, 64'h00000005_00000000);
    do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, r);
    chk("u_max_max", r, 64'h00000000_00000001);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.signed_i = 1'b0;
    bus.start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.annul_i = 1'b1;
    #1 chk("annul_stall_low", 64'(bus.stallreq_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o !== 1'b0) bad++;
    end
    chk("annul_no_ready", 64'(bad), 64'd0);
    do_div(32'd9, 32'd3, 1'b0, lat, r);
    chk("post_annul_latency", 64'(lat), 64'd33);
    chk("post_annul_result", r, 64'h00000000_00000003);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    wait_ready(lat, r);
    #2 rst = 1'b1;
    #1 chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("rst_mid_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_mid_result", bus.result_o, 64'd0);
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(lat, r);
    chk("post_rst_latency", 64'(lat), 64'd33);
    chk("post_rst_result", r, 64'h00000000_00000003);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port start_i, input, 1 bit: EX-stage divide request; held high until the result is consumed.
REQ-004 The block SHALL have port annul_i, input, 1 bit: cancel the in-flight divide (pipeline flush).
REQ-005 The block SHALL have port signed_i, input, 1 bit: 1 = DIV, 0 = DIVU.
REQ-006 The block SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-007 The block SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-008 The block SHALL have port result_o, output, 64 bits, registered: {remainder -> HI, quotient -> LO}.
REQ-009 The block SHALL have port ready_o, output, 1 bit, registered: result_o valid.
REQ-010 The block SHALL have port stallreq_o, output, 1 bit, combinational: pipeline stall request.

Function
REQ-011 The state machine SHALL have four states: FREE, BYZERO, ON, END.
REQ-012 In FREE with start_i=1, annul_i=0 and opdata2_i=0, the next state SHALL be BYZERO.
REQ-013 In FREE with start_i=1, annul_i=0 and opdata2_i!=0, the next state SHALL be ON, the operands SHALL be latched and the 6-bit iteration counter SHALL be cleared.
REQ-014 In ON, each edge SHALL perform one restoring shift-subtract step on a 65-bit {rem, dividend} register and increment the counter; the counter SHALL never wrap.
REQ-015 ON SHALL perform exactly 32 steps; the edge following the 32nd step SHALL move to END.
REQ-016 BYZERO SHALL move to END on the next edge with result zero.
REQ-017 In END, result_o SHALL be set to {remainder, quotient} and ready_o SHALL be set to 1 on the entering edge.
REQ-018 END SHALL hold result_o and ready_o until start_i=0, then return to FREE with ready_o=0 and result_o=0.
REQ-019 Latency: edge 0 is the first edge sampling start_i=1 in FREE; ready_o SHALL go high after edge 33 (nonzero divisor) or after edge 1 (zero divisor).
REQ-020 stallreq_o SHALL equal start_i AND NOT ready_o AND NOT annul_i.
REQ-021 annul_i=1 in any state other than END SHALL force FREE on the next edge, with no ready_o pulse.
REQ-022 annul_i=1 in END SHALL also force FREE, with ready_o=0.
REQ-023 opdata1_i/opdata2_i changes after edge 0 SHALL NOT affect the result.
REQ-024 Unsigned division: quotient = floor(a/b), remainder = a mod b.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state FREE, counter 0, result_o 0, ready_o 0.
REQ-026 rst=1 mid-divide SHALL discard the operation; after release, the block SHALL accept a new start_i on the first edge.

Configuration
REQ-027 The block SHALL use macro DIV_SIGNED_EN.
REQ-028 With DIV_SIGNED_EN defined and signed_i=1, the block SHALL divide the operand magnitudes (two's complement), negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-029 With DIV_SIGNED_EN defined, 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-030 Without DIV_SIGNED_EN, signed_i SHALL be ignored and all divides SHALL be unsigned; the negation logic SHALL NOT be synthesised.

Verification
REQ-031 Unsigned: 100 / 7, start held -> ready_o after edge 33, result_o = 0x00000002_0000000E; stallreq_o high for cycles 0-33, low once ready_o=1.
REQ-032 Signed (DIV_SIGNED_EN defined): 0xFFFFFFF9 / 2, signed_i=1 -> result_o = 0xFFFFFFFF_FFFFFFFD.
REQ-033 Without DIV_SIGNED_EN: 0xFFFFFFF9 / 2, signed_i=1 -> result_o = 0x00000001_7FFFFFFC.
REQ-034 Divide by zero: 5 / 0 -> BYZERO then END, ready_o after edge 1, result_o = 0; drop start_i -> FREE with ready_o=0.
REQ-035 Annul: annul_i pulsed at edge 10 of 100 / 7 -> FREE at edge 11, ready_o never asserted; a new 9 / 3 then yields 0x00000000_00000003.
REQ-036 Reset mid-op: rst asserted between edges 20 and 21 -> ready_o and result_o zero immediately; a divide after release completes normally.
